// File: rtl/decode_pkg.sv
// Shared decode definitions: base opcodes, immediate format codes and the
// canonical bubble instruction used by the IF/ID stage and later stages.
package decode_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational opcode classifier and immediate assembler. Produces the
// immediate format, the sign-extended immediate and the raw (unmasked)
// register-use and legality flags for one instruction word.
module imm_gen
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [2:0]      imm_type,
  output logic [XLEN-1:0] imm_ext,
  output logic            legal,
  output logic            uses_rs1,
  output logic            uses_rs2
);

  imm_type_e          imm_type_s;
  logic signed [31:0] imm32_s;
  logic               legal_s;
  logic               uses_rs1_s;
  logic               uses_rs2_s;

  // Classify the opcode and assemble the 32-bit immediate for its format.
  always_comb begin
    imm_type_s = IMM_NONE;
    imm32_s    = 32'sd0;
    legal_s    = 1'b0;
    uses_rs1_s = 1'b0;
    uses_rs2_s = 1'b0;
    case (instr[6:0])
      OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM: begin
        imm_type_s = IMM_I;
        imm32_s    = {{20{instr[31]}}, instr[31:20]};
        legal_s    = 1'b1;
        uses_rs1_s = 1'b1;
      end
      OPC_STORE: begin
        imm_type_s = IMM_S;
        imm32_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        legal_s    = 1'b1;
        uses_rs1_s = 1'b1;
        uses_rs2_s = 1'b1;
      end
      OPC_BRANCH: begin
        imm_type_s = IMM_B;
        imm32_s    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        legal_s    = 1'b1;
        uses_rs1_s = 1'b1;
        uses_rs2_s = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm_type_s = IMM_U;
        imm32_s    = {instr[31:12], 12'b0};
        legal_s    = 1'b1;
      end
      OPC_JAL: begin
        imm_type_s = IMM_J;
        imm32_s    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        legal_s    = 1'b1;
      end
      OPC_OP: begin
        imm_type_s = IMM_NONE;
        imm32_s    = 32'sd0;
        legal_s    = 1'b1;
        uses_rs1_s = 1'b1;
        uses_rs2_s = 1'b1;
      end
      default: begin
        imm_type_s = IMM_NONE;
        imm32_s    = 32'sd0;
        legal_s    = 1'b0;
        uses_rs1_s = 1'b0;
        uses_rs2_s = 1'b0;
      end
    endcase
  end

  // The signed size cast replicates bit 31 up to XLEN for 64-bit datapaths.
  assign imm_type = imm_type_s;
  assign imm_ext  = XLEN'(imm32_s);
  assign legal    = legal_s;
  assign uses_rs1 = uses_rs1_s;
  assign uses_rs2 = uses_rs2_s;

endmodule

// File: rtl/decode_stage.sv
// IF/ID pipeline register with stall/flush control, field split, immediate
// generation, hazard-relevant register-use flags, illegal-opcode flag and a
// saturating bubble counter for performance monitoring.
module decode_stage
  import decode_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = NOP_INSTR_DEFAULT,
  parameter int              CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instrF,
  input  logic [XLEN-1:0]  pcF,
  input  logic [XLEN-1:0]  pc_plus4F,
  input  logic             validF,
  input  logic             stallD,
  input  logic             flushD,
  output logic [31:0]      instrD,
  output logic [XLEN-1:0]  pcD,
  output logic [XLEN-1:0]  pc_plus4D,
  output logic             validD,
  output logic [6:0]       OP,
  output logic [4:0]       RdD,
  output logic [4:0]       Rs1D,
  output logic [4:0]       Rs2D,
  output logic [2:0]       funct3,
  output logic [6:0]       funct77,
  output logic             funct7,
  output logic [XLEN-1:0]  ImmExtD,
  output logic [2:0]       imm_type,
  output logic             rs1_used,
  output logic             rs2_used,
  output logic             illegalD,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [XLEN-1:0]  RESET_PC4 = RESET_PC + XLEN'(32'd4);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);

  logic [31:0]      instr_r;
  logic [XLEN-1:0]  pc_r;
  logic [XLEN-1:0]  pc_plus4_r;
  logic             valid_r;
  logic [CNT_W-1:0] bubble_cnt_r;

  logic             legal_s;
  logic             uses_rs1_s;
  logic             uses_rs2_s;

  // Stage register: reset > flush > stall > load; invalid fetches become NOPs.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_r    <= NOP_INSTR;
      pc_r       <= RESET_PC;
      pc_plus4_r <= RESET_PC4;
      valid_r    <= 1'b0;
    end else if (flushD) begin
      instr_r    <= NOP_INSTR;
      pc_r       <= pcF;
      pc_plus4_r <= pc_plus4F;
      valid_r    <= 1'b0;
    end else if (stallD) begin
      instr_r    <= instr_r;
      pc_r       <= pc_r;
      pc_plus4_r <= pc_plus4_r;
      valid_r    <= valid_r;
    end else begin
      instr_r    <= validF ? instrF : NOP_INSTR;
      pc_r       <= pcF;
      pc_plus4_r <= pc_plus4F;
      valid_r    <= validF;
    end
  end

  // Count cycles in which the stage holds a bubble, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_r <= '0;
    end else if (!valid_r && (bubble_cnt_r != CNT_MAX)) begin
      bubble_cnt_r <= bubble_cnt_r + CNT_ONE;
    end else begin
      bubble_cnt_r <= bubble_cnt_r;
    end
  end

  imm_gen #(
    .XLEN(XLEN)
  ) u_imm_gen (
    .instr    (instr_r),
    .imm_type (imm_type),
    .imm_ext  (ImmExtD),
    .legal    (legal_s),
    .uses_rs1 (uses_rs1_s),
    .uses_rs2 (uses_rs2_s)
  );

  assign instrD     = instr_r;
  assign pcD        = pc_r;
  assign pc_plus4D  = pc_plus4_r;
  assign validD     = valid_r;
  assign bubble_cnt = bubble_cnt_r;

  assign OP      = instr_r[6:0];
  assign RdD     = instr_r[11:7];
  assign Rs1D    = instr_r[19:15];
  assign Rs2D    = instr_r[24:20];
  assign funct3  = instr_r[14:12];
  assign funct77 = instr_r[31:25];
  assign funct7  = instr_r[30];

  // Bubbles must never raise hazards or illegal-instruction traps.
  assign rs1_used = valid_r & uses_rs1_s;
  assign rs2_used = valid_r & uses_rs2_s;
  assign illegalD = valid_r & ~legal_s;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, each immediate format, stall/flush
// interplay, illegal opcodes and bubble-counter saturation (CNT_W=4).
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic [31:0] instrF;
  logic [31:0] pcF;
  logic [31:0] pc_plus4F;
  logic        validF;
  logic        stallD;
  logic        flushD;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic [31:0] pc_plus4D;
  logic        validD;
  logic [6:0]  OP;
  logic [4:0]  RdD;
  logic [4:0]  Rs1D;
  logic [4:0]  Rs2D;
  logic [2:0]  funct3;
  logic [6:0]  funct77;
  logic        funct7;
  logic [31:0] ImmExtD;
  logic [2:0]  imm_type;
  logic        rs1_used;
  logic        rs2_used;
  logic        illegalD;
  logic [3:0]  bubble_cnt;

  int total = 0;
  int bad   = 0;

  decode_stage #(
    .XLEN(32), .RESET_PC(32'h0), .NOP_INSTR(32'h0000_0013), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .instrF(instrF), .pcF(pcF), .pc_plus4F(pc_plus4F),
    .validF(validF), .stallD(stallD), .flushD(flushD), .instrD(instrD),
    .pcD(pcD), .pc_plus4D(pc_plus4D), .validD(validD), .OP(OP), .RdD(RdD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .funct3(funct3), .funct77(funct77),
    .funct7(funct7), .ImmExtD(ImmExtD), .imm_type(imm_type),
    .rs1_used(rs1_used), .rs2_used(rs2_used), .illegalD(illegalD),
    .bubble_cnt(bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; validF = 1'b1; instrF = 32'hFFF1_0093;
    pcF = 32'h0; pc_plus4F = 32'h4; stallD = 1'b0; flushD = 1'b0;

    // reset state
    tick();
    check("rst_instrD", instrD, 32'h0000_0013);
    check("rst_validD", validD, 1'b0);
    check("rst_bubble", bubble_cnt, 4'd0);
    check("rst_pcD", pcD, 32'h0);
    check("rst_pc4D", pc_plus4D, 32'h4);
    check("rst_rs1_used", rs1_used, 1'b0);

    // addi x1,x2,-1 ; bubble counted on this edge (validD was 0)
    rst = 1'b0;
    tick();
    check("i_rd", RdD, 5'd1);
    check("i_rs1", Rs1D, 5'd2);
    check("i_type", imm_type, 3'd1);
    check("i_imm", ImmExtD, 32'hFFFF_FFFF);
    check("i_rs1_used", rs1_used, 1'b1);
    check("i_rs2_used", rs2_used, 1'b0);
    check("i_validD", validD, 1'b1);
    check("i_bubble", bubble_cnt, 4'd1);

    // sw x5,8(x2)
    instrF = 32'h0051_2423; pcF = 32'h4; pc_plus4F = 32'h8;
    tick();
    check("s_type", imm_type, 3'd2);
    check("s_imm", ImmExtD, 32'h8);
    check("s_rs1", Rs1D, 5'd2);
    check("s_rs2", Rs2D, 5'd5);
    check("s_rs2_used", rs2_used, 1'b1);
    check("s_funct3", funct3, 3'd2);

    // beq x0,x0,-4
    instrF = 32'hFE00_0EE3; pcF = 32'h8; pc_plus4F = 32'hC;
    tick();
    check("b_type", imm_type, 3'd3);
    check("b_imm", ImmExtD, 32'hFFFF_FFFC);
    check("b_funct77", funct77, 7'h7F);

    // lui x3,0x12345
    instrF = 32'h1234_51B7; pcF = 32'h100; pc_plus4F = 32'h104;
    tick();
    check("u_type", imm_type, 3'd4);
    check("u_imm", ImmExtD, 32'h1234_5000);
    check("u_rd", RdD, 5'd3);
    check("u_rs1_used", rs1_used, 1'b0);
    check("u_pcD", pcD, 32'h100);
    check("u_pc4D", pc_plus4D, 32'h104);
    check("u_bubble", bubble_cnt, 4'd1);

    // stall for 3 cycles while fetch keeps changing
    stallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      instrF = 32'hA5A5_0000 + i; pcF = 32'h300 + 4 * i; pc_plus4F = pcF + 32'd4;
      tick();
      check("stall_instrD", instrD, 32'h1234_51B7);
      check("stall_pcD", pcD, 32'h100);
    end
    check("stall_bubble", bubble_cnt, 4'd1);

    // stall and flush together: flush wins, PC still loads
    flushD = 1'b1; pcF = 32'h200; pc_plus4F = 32'h204;
    tick();
    check("flush_instrD", instrD, 32'h0000_0013);
    check("flush_validD", validD, 1'b0);
    check("flush_pcD", pcD, 32'h200);
    check("flush_bubble", bubble_cnt, 4'd1);
    check("flush_rs1_used", rs1_used, 1'b0);
    check("flush_illegal", illegalD, 1'b0);

    // stalled bubble keeps counting
    flushD = 1'b0;
    tick();
    check("stallbub_bubble1", bubble_cnt, 4'd2);
    tick();
    check("stallbub_bubble2", bubble_cnt, 4'd3);
    check("stallbub_pcD", pcD, 32'h200);

    // illegal opcode with validF=1
    stallD = 1'b0; instrF = 32'h0000_007F; validF = 1'b1;
    tick();
    check("ill_illegal", illegalD, 1'b1);
    check("ill_imm", ImmExtD, 32'h0);
    check("ill_type", imm_type, 3'd0);
    check("ill_rs1_used", rs1_used, 1'b0);
    check("ill_bubble", bubble_cnt, 4'd4);

    // same word, not valid -> NOP bubble, no illegal flag
    validF = 1'b0;
    tick();
    check("inv_illegal", illegalD, 1'b0);
    check("inv_instrD", instrD, 32'h0000_0013);
    check("inv_validD", validD, 1'b0);
    check("inv_bubble", bubble_cnt, 4'd4);

    // saturation: 4 + 10 = 14, +1 = 15, then stuck
    for (int i = 0; i < 10; i++) tick();
    check("sat_bubble14", bubble_cnt, 4'd14);
    tick();
    check("sat_bubble15", bubble_cnt, 4'd15);
    for (int i = 0; i < 9; i++) tick();
    check("sat_hold", bubble_cnt, 4'd15);

    // reset mid-run clears the counter
    rst = 1'b1;
    tick();
    check("rst2_bubble", bubble_cnt, 4'd0);
    check("rst2_validD", validD, 1'b0);

    // add x3,x1,x2 (R format)
    rst = 1'b0; validF = 1'b1; instrF = 32'h0020_81B3; pcF = 32'h40; pc_plus4F = 32'h44;
    tick();
    check("r_type", imm_type, 3'd0);
    check("r_imm", ImmExtD, 32'h0);
    check("r_rs1_used", rs1_used, 1'b1);
    check("r_rs2_used", rs2_used, 1'b1);
    check("r_illegal", illegalD, 1'b0);
    check("r_bubble", bubble_cnt, 4'd1);

    // jal x0,8 ; sub-style funct7 bit check on a second R word afterwards
    instrF = 32'h0080_006F;
    tick();
    check("j_type", imm_type, 3'd5);
    check("j_imm", ImmExtD, 32'h8);
    check("j_rs1_used", rs1_used, 1'b0);

    // sub x3,x1,x2
    instrF = 32'h4020_81B3;
    tick();
    check("sub_funct7", funct7, 1'b1);
    check("sub_op", OP, 7'h33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
